// File: rtl/cnn_window_gen_pkg.sv
// Shared constants and state encoding for the cnn_core window source.
// Optional macro CNN_WIN_STRIDE2_EN (used in cnn_window_gen) selects stride-2 window emission.
package cnn_window_gen_pkg;

  localparam int CNN_CI     = 3;
  localparam int CNN_KX     = 3;
  localparam int CNN_KY     = 3;
  localparam int CNN_I_F_BW = 8;
  localparam int CNN_IW     = 28;
  localparam int CNN_IH     = 28;

  // Packed window width, shared with cnn_core i_in_fmap.
  localparam int CNN_FMAP_BW = CNN_CI * CNN_KX * CNN_KY * CNN_I_F_BW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_window_gen_line_buffer.sv
// KY-1 image rows of pixels; column at i_addr is read and shifted down one row in the same cycle.
// Write-at-addr / read-at-addr structure maps onto RAM.
module cnn_line_buffer #(
  parameter int ROWS  = 2,
  parameter int DEPTH = 28,
  parameter int W     = 24,
  parameter int AW    = 5
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_addr,
  input  logic [W-1:0]       i_din,
  output logic [ROWS*W-1:0]  o_col
);

  logic [W-1:0] r_mem [ROWS][DEPTH];

  // Row 0 is the most recent row; o_col returns pre-write contents.
  for (genvar k = 0; k < ROWS; k++) begin : g_rd
    assign o_col[k*W +: W] = r_mem[k][i_addr];
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[0][i_addr] <= i_din;
      for (int k = 1; k < ROWS; k++) begin
        r_mem[k][i_addr] <= r_mem[k-1][i_addr];
      end
    end
  end

endmodule

// File: rtl/cnn_window_gen.sv
// Raster pixel stream to packed CI*KX*KY convolution windows for cnn_core.
// Macro CNN_WIN_STRIDE2_EN: emit only windows at even row/col offsets (stride 2).
//
// state  | meaning
// IDLE   | waiting for i_start; pixels ignored
// ACTIVE | accepting pixels of the current frame
// DONE   | one-cycle frame-end pulse on o_done
module cnn_window_gen
  import cnn_window_gen_pkg::*;
#(
  parameter int CI     = CNN_CI,
  parameter int KX     = CNN_KX,
  parameter int KY     = CNN_KY,
  parameter int I_F_BW = CNN_I_F_BW,
  parameter int IW     = CNN_IW,
  parameter int IH     = CNN_IH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_soft_reset,
  input  logic                          i_start,
  input  logic                          i_in_valid,
  input  logic [CI*I_F_BW-1:0]          i_in_pixel,
  output logic                          o_ot_valid,
  output logic [CI*KX*KY*I_F_BW-1:0]    o_ot_fmap,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int PW    = CI * I_F_BW;
  localparam int FW    = CI * KX * KY * I_F_BW;
  localparam int COL_W = cnt_w(IW);
  localparam int ROW_W = cnt_w(IH);

  state_t              r_state, w_next;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [PW-1:0]       r_hist [KY][KX-1];
  logic [PW-1:0]       w_new_win [KY][KX];
  logic [(KY-1)*PW-1:0] w_lb_col;
  logic [FW-1:0]       w_packed;
  logic                r_ot_valid;
  logic [FW-1:0]       r_ot_fmap;
  logic                w_accept, w_last_col, w_last_row, w_emit;

  assign w_accept   = (r_state == ST_ACTIVE) && i_in_valid;
  assign w_last_col = (r_col == COL_W'(IW-1));
  assign w_last_row = (r_row == ROW_W'(IH-1));

`ifdef CNN_WIN_STRIDE2_EN
  logic [COL_W-1:0] w_col_off;
  logic [ROW_W-1:0] w_row_off;
  assign w_col_off = r_col - COL_W'(KX-1);
  assign w_row_off = r_row - ROW_W'(KY-1);
  assign w_emit = (r_row >= ROW_W'(KY-1)) && (r_col >= COL_W'(KX-1)) &&
                  !w_row_off[0] && !w_col_off[0];
`else
  assign w_emit = (r_row >= ROW_W'(KY-1)) && (r_col >= COL_W'(KX-1));
`endif

  cnn_line_buffer #(
    .ROWS (KY-1),
    .DEPTH(IW),
    .W    (PW),
    .AW   (COL_W)
  ) u_lbuf (
    .clk   (clk),
    .i_we  (w_accept),
    .i_addr(r_col),
    .i_din (i_in_pixel),
    .o_col (w_lb_col)
  );

  // Window after shifting in the incoming column; ky=0 is the oldest row.
  for (genvar ky = 0; ky < KY; ky++) begin : g_ky
    for (genvar kx = 0; kx < KX; kx++) begin : g_kx
      if (kx < KX-1) begin : g_old
        assign w_new_win[ky][kx] = r_hist[ky][kx];
      end else if (ky == KY-1) begin : g_pix
        assign w_new_win[ky][kx] = i_in_pixel;
      end else begin : g_lb
        assign w_new_win[ky][kx] = w_lb_col[(KY-2-ky)*PW +: PW];
      end
      for (genvar c = 0; c < CI; c++) begin : g_c
        assign w_packed[((c*KY+ky)*KX+kx)*I_F_BW +: I_F_BW] =
          w_new_win[ky][kx][c*I_F_BW +: I_F_BW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int ky = 0; ky < KY; ky++) begin
        for (int j = 0; j < KX-1; j++) begin
          r_hist[ky][j] <= w_new_win[ky][j+1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else if (i_soft_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_next = ST_ACTIVE;
      ST_ACTIVE: if (w_accept && w_last_col && w_last_row) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == ST_ACTIVE);
    o_done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_ot_valid <= 1'b0;
      r_ot_fmap  <= '0;
    end else if (i_soft_reset) begin
      r_col      <= '0;
      r_row      <= '0;
      r_ot_valid <= 1'b0;
      r_ot_fmap  <= '0;
    end else begin
      r_ot_valid <= w_accept && w_emit;
      if (w_accept && w_emit) r_ot_fmap <= w_packed;
      if ((r_state == ST_IDLE) && i_start) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign o_ot_valid = r_ot_valid;
  assign o_ot_fmap  = r_ot_fmap;

endmodule

// File: doc/cnn_window_gen.md
Name: cnn_window_gen

Overview:
- Source side of the cnn_core input interface.
- Accepts a raster-order pixel stream (CI channels per pixel) and buffers KY-1 image rows in line buffers.
- Emits one packed CI*KX*KY window per valid convolution position on o_ot_valid / o_ot_fmap, wired directly to cnn_core i_in_valid / i_in_fmap.
- Framed by i_start / o_done; no backpressure, because cnn_core accepts every valid window.

Parameters:
- CI, 3, input channels per pixel
- KX, 3, kernel width
- KY, 3, kernel height
- I_F_BW, 8, bits per channel sample
- IW, 28, image width in pixels (must be >= KX)
- IH, 28, image height in pixels (must be >= KY)

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- i_soft_reset  in  1  synchronous clear; same effect as reset
- i_start  in  1  one-cycle pulse, arms a new frame
- i_in_valid  in  1  pixel strobe
- i_in_pixel  in  CI*I_F_BW  channel c at [c*I_F_BW +: I_F_BW]
- o_ot_valid  out  1  window strobe, one cycle per window
- o_ot_fmap  out  CI*KX*KY*I_F_BW  packed window
- o_busy  out  1  high in ACTIVE state
- o_done  out  1  one-cycle pulse at frame end

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset / soft reset values: o_ot_valid=0, o_ot_fmap=0, o_busy=0, o_done=0; state=IDLE; col=0, row=0.
  - Line-buffer contents are don't-care after reset.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE -> ACTIVE on i_start; col and row are cleared.
  - ACTIVE -> DONE on acceptance of pixel (row=IH-1, col=IW-1).
  - DONE -> IDLE unconditionally after 1 cycle; o_done=1 only in DONE.
  - i_start in ACTIVE or DONE is ignored.
  - i_in_valid in IDLE or DONE is ignored: no state or buffer change.
- Pixel acceptance (ACTIVE and i_in_valid):
  - Shift the window register left by one column. The new right column is {linebuf[KY-2][col] .. linebuf[0][col], i_in_pixel}, oldest row at top.
  - Line buffers update at col: linebuf[k] <= linebuf[k-1], linebuf[0] <= i_in_pixel.
  - col increments; at IW-1 it wraps to 0 and row increments.
- Gaps in i_in_valid are allowed; state holds while i_in_valid=0.
- Window emission:
  - If the accepted pixel satisfies row>=KY-1 and col>=KX-1, o_ot_valid=1 on the next cycle (latency 1), with the window that includes that pixel.
  - o_ot_fmap holds its value until the next window.
  - The window does not straddle rows: columns entering from the previous row are never emitted, because col>=KX-1 guarantees KX fresh columns.
- Window packing: element (c, ky, kx), with ky=0 the top row and kx=0 the leftmost column, occupies flat index ((c*KY+ky)*KX+kx)*I_F_BW, LSB first.
- Window count per frame is (IH-KY+1)*(IW-KX+1).
- The last window's o_ot_valid and o_done assert in the same cycle.
- Reset asserted mid-frame: immediate return to IDLE; a partial frame is discarded with no o_done.
- Counters are clog2-sized; all arithmetic is unsigned and pixels are passed through unmodified.

Optional Feature:
- Macro: CNN_WIN_STRIDE2_EN.
- Defined: a window is emitted only when (row-(KY-1)) and (col-(KX-1)) are both even (stride 2). Window count is ceil((IH-KY+1)/2)*ceil((IW-KX+1)/2).
- Undefined: stride 1, as above.
- Buffering and latency are identical in both builds.

Decomposition:
- Shared package / defines header holds CI, KX, KY, I_F_BW, IW, IH, the state encodings, and the packed-width constant CI*KX*KY*I_F_BW shared with cnn_core.
- One sub-module: cnn_line_buffer, holding the KY-1 rows of IW*CI*I_F_BW, with write-at-col and read-column-at-col in the same cycle. It is inferable as RAM.

Test Plan:
- Window contents and count: CI=1, KX=KY=3, IW=IH=4, I_F_BW=8, pixel value=row*4+col, continuous valid.
  - Exactly 4 windows.
  - First window, one cycle after pixel 10, is {0,1,2,4,5,6,8,9,10} in index order.
  - Last window is {5,6,7,9,10,11,13,14,15}.
  - o_done coincides with the last o_ot_valid.
- Gaps: same frame with i_in_valid toggling 1-0-0-1 -> identical windows in the same order, each window 1 cycle after its completing pixel.
- Idle filtering: pixels before i_start and i_start pulses mid-frame -> ignored; window count stays 4.
- Mid-frame reset: assert reset_n=0 after pixel 9.
  - All outputs go to 0 with no o_done.
  - A new i_start plus a full frame gives the correct 4 windows.
- Channel packing: CI=3, channel c = 16*c + pixel index -> o_ot_fmap places channel c at slots c*9..c*9+8.
- Stride 2 (CNN_WIN_STRIDE2_EN, IW=IH=5): exactly 4 windows, at pixel positions (2,2), (2,4), (4,2), (4,4).
